// File: rtl/bbox_scan_counter.sv
// Walks every pixel of a signed bounding box row by row, one coordinate per cycle under valid/ready.
// Reports completion with a one-cycle done pulse; empty flags an empty box or an aborted scan.
module bbox_scan_counter #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] x_min,
   input  logic [WIDTH-1:0] x_max,
   input  logic [WIDTH-1:0] y_min,
   input  logic [WIDTH-1:0] y_max,
   input  logic             out_ready,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             last_x,
   output logic             last,
   output logic             done,
   output logic             empty
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
   logic [WIDTH-1:0] r_x, r_y;
   logic             r_empty;
   logic             w_box_empty;
   logic             w_xfer;
   logic             w_last_x;
   logic             w_last;

   assign w_box_empty = ($signed(x_min) > $signed(x_max)) || ($signed(y_min) > $signed(y_max));
   assign w_xfer      = out_valid && out_ready;
   // End-of-row/frame compare the current value before increment, so max-positive bounds never wrap.
   assign w_last_x    = out_valid && (r_x == r_xmax);
   assign w_last      = w_last_x && (r_y == r_ymax);

   assign x      = r_x;
   assign y      = r_y;
   assign last_x = w_last_x;
   assign last   = w_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = w_box_empty ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (abort || (w_xfer && w_last)) begin
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      empty     = 1'b0;
      case (r_state)
         S_RUN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         S_DONE: begin
            busy  = 1'b1;
            done  = 1'b1;
            empty = r_empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_xmin  <= '0;
         r_xmax  <= '0;
         r_ymin  <= '0;
         r_ymax  <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_empty <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_xmin  <= x_min;
                  r_xmax  <= x_max;
                  r_ymin  <= y_min;
                  r_ymax  <= y_max;
                  r_x     <= x_min;
                  r_y     <= y_min;
                  r_empty <= w_box_empty;
               end
            end
            S_RUN: begin
               // Abort wins over a same-cycle transfer: the presented coordinate is dropped.
               if (abort) begin
                  r_empty <= 1'b1;
               end else if (w_xfer) begin
                  if (w_last) begin
                     r_empty <= 1'b0;
                  end else if (w_last_x) begin
                     r_x <= r_xmin;
                     r_y <= r_y + 1'b1;
                  end else begin
                     r_x <= r_x + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bbox_scan_counter.sv
// Bench for bbox_scan_counter: scans are checked against an expected coordinate list
// built with nested loops over the requested box.
module tb_bbox_scan_counter;
   localparam int WIDTH = 10;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] x_min, x_max, y_min, y_max;
   logic             out_ready;
   logic             busy, out_valid, last_x, last, done, empty;
   logic [WIDTH-1:0] x, y;

   int errors = 0;
   int checks = 0;

   bbox_scan_counter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .out_ready(out_ready), .busy(busy), .out_valid(out_valid),
      .x(x), .y(y), .last_x(last_x), .last(last), .done(done), .empty(empty)
   );

   always #5 clk = ~clk;

   // rmode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random ready.
   // abort_idx: index of the coordinate on which abort is raised (-1 = never).
   task automatic run_box(input int xmn, input int xmx, input int ymn, input int ymx,
                          input int rmode, input int abort_idx, input bit start_in_run);
      int exp_x[$];
      int exp_y[$];
      int idx;
      int want_xfers;
      bit expect_done, exp_empty, seen_done, aborted;
      for (int yy = ymn; yy <= ymx; yy++)
         for (int xx = xmn; xx <= xmx; xx++) begin
            exp_x.push_back(xx);
            exp_y.push_back(yy);
         end
      exp_empty = (exp_x.size() == 0);
      @(negedge clk);
      x_min = xmn[WIDTH-1:0];
      x_max = xmx[WIDTH-1:0];
      y_min = ymn[WIDTH-1:0];
      y_max = ymx[WIDTH-1:0];
      start = 1'b1;
      abort = 1'b0;
      out_ready = 1'b0;
      expect_done = exp_empty;
      @(negedge clk);
      start = 1'b0;
      x_min = WIDTH'($urandom);
      x_max = WIDTH'($urandom);
      y_min = WIDTH'($urandom);
      y_max = WIDTH'($urandom);
      idx = 0;
      seen_done = 1'b0;
      aborted = 1'b0;
      for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b want 1", cyc, busy);
         end
         if (done === 1'b1) begin
            seen_done = 1'b1;
            checks++;
            if (!expect_done) begin
               errors++;
               $display("FAIL done_early cyc=%0d got done=1 want 0", cyc);
            end
            checks++;
            if (empty !== (exp_empty || aborted)) begin
               errors++;
               $display("FAIL empty got %b want %b", empty, exp_empty || aborted);
            end
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL valid_in_done got %b want 0", out_valid);
            end
            want_xfers = aborted ? abort_idx : exp_x.size();
            checks++;
            if (idx != want_xfers) begin
               errors++;
               $display("FAIL xfer_count got %0d want %0d", idx, want_xfers);
            end
         end else begin
            checks++;
            if (expect_done) begin
               errors++;
               $display("FAIL done_late cyc=%0d got done=%b want 1", cyc, done);
            end
            checks++;
            if (out_valid !== 1'b1) begin
               errors++;
               $display("FAIL out_valid cyc=%0d got %b want 1", cyc, out_valid);
            end
            checks++;
            if (idx >= exp_x.size()) begin
               errors++;
               $display("FAIL extra_coord got (%0d,%0d) want none", $signed(x), $signed(y));
            end else if ($signed(x) !== exp_x[idx] || $signed(y) !== exp_y[idx]) begin
               errors++;
               $display("FAIL coord idx=%0d got (%0d,%0d) want (%0d,%0d)",
                        idx, $signed(x), $signed(y), exp_x[idx], exp_y[idx]);
            end else begin
               checks++;
               if (last_x !== (exp_x[idx] == xmx) || last !== (exp_x[idx] == xmx && exp_y[idx] == ymx)) begin
                  errors++;
                  $display("FAIL flags idx=%0d got last_x=%b last=%b want %b %b", idx, last_x, last,
                           exp_x[idx] == xmx, exp_x[idx] == xmx && exp_y[idx] == ymx);
               end
            end
            start = start_in_run && (cyc == 1);
            if (start) begin
               x_min = 10'd0; x_max = 10'd0; y_min = 10'd0; y_max = 10'd0;
            end
            case (rmode)
               0:       out_ready = 1'b1;
               1:       out_ready = (cyc % 3 == 0);
               default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            abort = (idx == abort_idx);
            if (abort) begin
               out_ready = 1'b1;
               aborted = 1'b1;
               expect_done = 1'b1;
            end else if (out_ready) begin
               if (idx == exp_x.size() - 1) expect_done = 1'b1;
               idx++;
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      abort = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (!seen_done) begin
         errors++;
         $display("FAIL timeout got no done want done");
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || empty !== 1'b0) begin
         errors++;
         $display("FAIL after_done got done=%b busy=%b valid=%b empty=%b want 0 0 0 0",
                  done, busy, out_valid, empty);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      x_min = '0; x_max = '0; y_min = '0; y_max = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, out_valid, done, empty, last_x, last} !== 6'b0 || x !== '0 || y !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b valid=%b done=%b empty=%b x=%0d y=%0d want all 0",
                  busy, out_valid, done, empty, x, y);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      run_box(0, 2, 0, 1, 0, -1, 1'b0);
   endtask

   task automatic test_stall();
      run_box(-3, -1, 5, 5, 1, -1, 1'b0);
   endtask

   task automatic test_empty();
      run_box(4, 3, 0, 0, 0, -1, 1'b0);
      run_box(0, 0, 0, -1, 0, -1, 1'b0);
   endtask

   task automatic test_max_bound();
      run_box(510, 511, 511, 511, 0, -1, 1'b0);
   endtask

   task automatic test_abort();
      run_box(0, 3, 0, 3, 0, 2, 1'b1);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      x_min = 10'd0; x_max = 10'd3; y_min = 10'd0; y_max = 10'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, out_valid, done, empty, last_x, last} !== 6'b0 || x !== '0 || y !== '0) begin
         errors++;
         $display("FAIL async_reset got busy=%b valid=%b done=%b empty=%b x=%0d y=%0d want all 0",
                  busy, out_valid, done, empty, x, y);
      end
      out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      run_box(1, 1, 1, 1, 0, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         int xmn, xmx, ymn, ymx, ab;
         xmn = int'($urandom_range(0, 8)) - 4;
         xmx = xmn + int'($urandom_range(0, 5)) - 1;
         ymn = int'($urandom_range(0, 8)) - 4;
         ymx = ymn + int'($urandom_range(0, 4)) - 1;
         ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
         run_box(xmn, xmx, ymn, ymx, 2, ab, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_empty();
      test_max_bound();
      test_abort();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
